// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg
//   Shared CPU constants for the multicycle multiply/divide engine.
//   - WIDTH          : operand width (results are 2*WIDTH as {hi, lo})
//   - MD_OP_*        : encodings of the engine's op input
//   - ALU_OP_*       : ALU opcode values that the control unit routes to the
//                      engine instead of the combinational ALU
//   - md_state_e     : engine FSM states
//   - cond_neg()     : two's-complement negate when a flag is set
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = $clog2(WIDTH);

   // Iteration counter value on the last Booth / non-restoring step.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic MD_OP_MUL = 1'b0;
   localparam logic MD_OP_DIV = 1'b1;

   localparam logic [4:0] ALU_OP_MUL = 5'b01111;
   localparam logic [4:0] ALU_OP_DIV = 5'b10000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } md_state_e;

   // Map an ALU opcode onto the engine op bit (only meaningful for MUL/DIV).
   function automatic logic alu_to_md_op(input logic [4:0] alu_op);
      return (alu_op == ALU_OP_DIV) ? MD_OP_DIV : MD_OP_MUL;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                 input logic             neg);
      return neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
   endfunction

endpackage

// File: rtl/mul_div_unit_addsub.sv
// ---------------------------------------------------------------------------
// md_addsub
//   (WIDTH+1)-bit adder/subtractor shared by Booth partial-product
//   accumulation and the non-restoring remainder update.
//   Ports:
//     a, b : WIDTH+1-bit operands
//     sub  : 0 -> y = a + b, 1 -> y = a - b
//     y    : WIDTH+1-bit result (carry out discarded)
// ---------------------------------------------------------------------------
module md_addsub
   import mul_div_unit_pkg::*;
(
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           sub,
   output logic [WIDTH:0] y
);

   // Subtract as a + ~b + 1 so one carry chain serves both operations.
   assign y = a + (b ^ {(WIDTH+1){sub}}) + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Multicycle signed multiply / divide engine sitting beside the ALU.
//   Operand A comes from Y, operand B from the bus; the {hi, lo} result feeds
//   ZHigh/ZLow. Multiply is radix-2 Booth (WIDTH edges); divide is
//   non-restoring on magnitudes (WIDTH edges) followed by a sign-fixup edge.
//   Ports:
//     clock, clear_n        : clock, asynchronous active-low reset
//     start, op             : request (sampled when not busy), 0=mul 1=div
//     operand_a, operand_b  : multiplicand/dividend, multiplier/divisor
//     busy                  : operation in progress, start ignored
//     done                  : one-cycle pulse, results valid from here on
//     result_hi, result_lo  : mul {product hi, lo}; div {remainder, quotient}
//     div_by_zero           : raised with done when the divisor was zero
// ---------------------------------------------------------------------------
module mul_div_unit
   import mul_div_unit_pkg::*;
(
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             div_by_zero
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // acc: Booth accumulator (mul) / partial remainder (div), one guard bit.
   logic [WIDTH:0]   acc_q, acc_d;
   // q: multiplier shifting out (mul) / dividend in, quotient out (div).
   logic [WIDTH-1:0] q_q, q_d;
   logic             qm1_q, qm1_d;
   // m: multiplicand (mul) / divisor magnitude (div).
   logic [WIDTH-1:0] m_q, m_d;
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   as_a, as_b, as_y;
   logic             as_sub;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH-1:0] rem_mag;

   md_addsub u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .y   (as_y)
   );

   // Adder operand steering per state.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
      as_a   = acc_q;
      as_b   = {m_q[WIDTH-1], m_q};
      as_sub = 1'b0;
      unique case (state_q)
         ST_MUL: begin
            // Booth pair {q0, q-1}: 10 subtracts, 01 adds the multiplicand.
            as_b   = {m_q[WIDTH-1], m_q};
            as_sub = q_q[0];
         end
         ST_DIV: begin
            // Shift {R, Q} left one, then subtract if R was non-negative,
            // otherwise add the divisor back.
            as_a   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
            as_b   = {1'b0, m_q};
            as_sub = ~acc_q[WIDTH];
         end
         ST_FIX: begin
            // Final restore of a negative remainder.
            as_a   = acc_q;
            as_b   = {1'b0, m_q};
            as_sub = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;

      booth_sum = (q_q[0] ^ qm1_q) ? as_y : acc_q;
      rem_mag   = acc_q[WIDTH] ? as_y[WIDTH-1:0] : acc_q[WIDTH-1:0];

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (start) begin
               busy_d  = 1'b1;
               dbz_d   = 1'b0;
               cnt_d   = '0;
               acc_d   = '0;
               qm1_d   = 1'b0;
               a_neg_d = operand_a[WIDTH-1];
               b_neg_d = operand_b[WIDTH-1];
               if (op == MD_OP_MUL) begin
                  state_d = ST_MUL;
                  q_d     = operand_b;
                  m_d     = operand_a;
               end else begin
                  state_d = ST_DIV;
                  q_d     = cond_neg(operand_a, operand_a[WIDTH-1]);
                  m_d     = cond_neg(operand_b, operand_b[WIDTH-1]);
               end
            end
         end

         ST_MUL: begin
            // Arithmetic shift right of {acc, q, q-1} after the add/sub.
            acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               hi_d    = acc_d[WIDTH-1:0];
               lo_d    = q_d;
            end
         end

         ST_DIV: begin
            if (m_q == '0) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               dbz_d   = 1'b1;
               lo_d    = '1;
               hi_d    = cond_neg(q_q, a_neg_q);
            end else begin
               acc_d = as_y;
               q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_FIX;
               end
            end
         end

         ST_FIX: begin
            // Quotient truncates toward zero; remainder follows the dividend.
            hi_d    = cond_neg(rem_mag, a_neg_q);
            lo_d    = cond_neg(q_q, a_neg_q ^ b_neg_q);
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: all state, including the datapath registers, is reset so outputs read 0 under clear_n.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign result_hi   = hi_q;
   assign result_lo   = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed bench for mul_div_unit: handshake timing, signed mul/div
//   results, divide by zero, ignored start while busy, back-to-back accept
//   and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic             clock = 1'b0;
   logic             clear_n;
   logic             start;
   logic             op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;
   logic             div_by_zero;

   int checks   = 0;
   int failures = 0;

   mul_div_unit dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                        input logic [WIDTH-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Present a request so the next rising edge is the accept edge E0,
   // then scramble the operand inputs to show they were latched.
   task automatic accept(input logic o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
      @(negedge clock);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      @(posedge clock);
      #1;
      start     = 1'b0;
      operand_a = 32'hDEAD_BEEF;
      operand_b = 32'h0000_0000;
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int done_seen;

      clear_n   = 1'b0;
      start     = 1'b0;
      op        = MD_OP_MUL;
      operand_a = '0;
      operand_b = '0;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", result_hi, 0);
      check("rst_lo", result_lo, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clock);
      clear_n = 1'b1;

      // 1. mul 20 x 5: busy window and done timing
      accept(MD_OP_MUL, 32'd20, 32'd5);
      check("mul1_e0_busy", busy, 1);
      check("mul1_e0_done", done, 0);
      bad = 0;
      for (int i = 1; i <= 31; i++) begin
         step(1);
         if (!(busy === 1'b1 && done === 1'b0)) bad++;
      end
      check("mul1_busy_window", bad, 0);
      step(1);
      check("mul1_e32_done", done, 1);
      check("mul1_e32_busy", busy, 0);
      check("mul1_hi", result_hi, 32'h0000_0000);
      check("mul1_lo", result_lo, 32'h0000_0064);
      step(1);
      check("mul1_done_pulse", done, 0);
      check("mul1_idle_busy", busy, 0);
      check("mul1_lo_hold", result_lo, 32'h0000_0064);

      // 2. Signed and extreme multiplies
      accept(MD_OP_MUL, 32'hFFFF_FFF9, 32'd3);
      step(32);
      check("mul2_done", done, 1);
      check("mul2_hi", result_hi, 32'hFFFF_FFFF);
      check("mul2_lo", result_lo, 32'hFFFF_FFEB);
      accept(MD_OP_MUL, 32'h8000_0000, 32'h8000_0000);
      step(32);
      check("mul3_hi", result_hi, 32'h4000_0000);
      check("mul3_lo", result_lo, 32'h0000_0000);

      // 3. Divides: latency 33 edges, sign rules
      accept(MD_OP_DIV, 32'd20, 32'd5);
      step(32);
      check("div1_e32_done", done, 0);
      check("div1_e32_busy", busy, 1);
      step(1);
      check("div1_e33_done", done, 1);
      check("div1_lo", result_lo, 32'd4);
      check("div1_hi", result_hi, 32'd0);
      accept(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
      step(33);
      check("div2_lo", result_lo, 32'hFFFF_FFFD);
      check("div2_hi", result_hi, 32'hFFFF_FFFF);
      accept(MD_OP_DIV, 32'd7, 32'hFFFF_FFFE);
      step(33);
      check("div3_lo", result_lo, 32'hFFFF_FFFD);
      check("div3_hi", result_hi, 32'h0000_0001);

      // 4. Divide by zero, then a mul accepted from DONE clears the flag
      accept(MD_OP_DIV, 32'h1234_5678, 32'd0);
      step(1);
      check("dbz_done", done, 1);
      check("dbz_busy", busy, 0);
      check("dbz_flag", div_by_zero, 1);
      check("dbz_lo", result_lo, 32'hFFFF_FFFF);
      check("dbz_hi", result_hi, 32'h1234_5678);
      accept(MD_OP_MUL, 32'd3, 32'hFFFF_FFFF);
      check("dbz_clear_at_accept", div_by_zero, 0);
      check("dbz_next_busy", busy, 1);
      check("dbz_hi_hold", result_hi, 32'h1234_5678);
      step(32);
      check("mul4_hi", result_hi, 32'hFFFF_FFFF);
      check("mul4_lo", result_lo, 32'hFFFF_FFFD);

      // 5. Start while busy is ignored; back-to-back accept from DONE
      accept(MD_OP_MUL, 32'd1234, 32'd1000);
      step(4);
      @(negedge clock);
      start     = 1'b1;
      op        = MD_OP_DIV;
      operand_a = 32'd9;
      operand_b = 32'd9;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("ign_busy", busy, 1);
      step(27);
      check("ign_done", done, 1);
      check("ign_hi", result_hi, 32'h0000_0000);
      check("ign_lo", result_lo, 32'h0012_D450);
      accept(MD_OP_DIV, 32'd100, 32'd7);
      check("b2b_busy", busy, 1);
      check("b2b_done", done, 0);
      step(33);
      check("b2b_done_e33", done, 1);
      check("b2b_lo", result_lo, 32'd14);
      check("b2b_hi", result_hi, 32'd2);

      // 6. Asynchronous reset mid-divide, then -2^31 / -1
      accept(MD_OP_DIV, 32'd1000, 32'd3);
      step(10);
      #2;
      clear_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_hi", result_hi, 0);
      check("arst_lo", result_lo, 0);
      step(2);
      @(negedge clock);
      clear_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (done !== 1'b0) done_seen++;
      end
      check("arst_no_done", done_seen, 0);
      accept(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      step(33);
      check("ovf_done", done, 1);
      check("ovf_lo", result_lo, 32'h8000_0000);
      check("ovf_hi", result_hi, 32'h0000_0000);
      check("ovf_dbz", div_by_zero, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
